// File: rtl/frame_result_writer.sv
// rtl/frame_result_writer.sv - stores a filtered raster frame, then drains it over valid/ready
module frame_result_writer #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_pixel,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_pixel,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DEPTH = IMG_W * IMG_H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [RW-1:0] wr_row, rd_row;
    logic [CW-1:0] wr_col, rd_col;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          wr_last, rd_last;
    logic          rd_done;
    logic          wr_en, rd_load, accept_start, drain_entry;

    assign wr_addr = AW'(wr_row) * AW'(IMG_W) + AW'(wr_col);
    assign rd_addr = AW'(rd_row) * AW'(IMG_W) + AW'(rd_col);
    assign wr_last = (wr_row == ROW_LAST) && (wr_col == COL_LAST);
    assign rd_last = (rd_row == ROW_LAST) && (rd_col == COL_LAST);

    assign busy       = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
    assign frame_done = (state_q == S_DONE);

    // Next-state and per-cycle strobes; the drain prefetches whenever the output slot is empty or being emptied
    always_comb begin
        state_d      = state_q;
        wr_en        = 1'b0;
        rd_load      = 1'b0;
        accept_start = 1'b0;
        drain_entry  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_last) begin
                        state_d     = S_DRAIN;
                        drain_entry = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                rd_load = !rd_done && (!out_valid || out_ready);
                if (out_valid && out_ready && rd_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register and write-side raster counters; counters park on the last pixel instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wr_row  <= '0;
            wr_col  <= '0;
        end else begin
            state_q <= state_d;
            if (accept_start) begin
                wr_row <= '0;
                wr_col <= '0;
            end else if (wr_en && !wr_last) begin
                if (wr_col == COL_LAST) begin
                    wr_col <= '0;
                    wr_row <= wr_row + 1'b1;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end
        end
    end

    // Frame storage; not reset, only written during capture
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_pixel;
        end
    end

    // Read-side counters and the registered output slot; rd_done marks that the final pixel is loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_row    <= '0;
            rd_col    <= '0;
            rd_done   <= 1'b0;
            out_valid <= 1'b0;
            out_pixel <= '0;
        end else begin
            if (drain_entry) begin
                rd_row  <= '0;
                rd_col  <= '0;
                rd_done <= 1'b0;
            end else if (rd_load) begin
                if (rd_last) begin
                    rd_done <= 1'b1;
                end else if (rd_col == COL_LAST) begin
                    rd_col <= '0;
                    rd_row <= rd_row + 1'b1;
                end else begin
                    rd_col <= rd_col + 1'b1;
                end
            end
            if (rd_load) begin
                out_valid <= 1'b1;
                out_pixel <= mem[rd_addr];
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Sticky overrun: any beat offered outside capture is dropped and flagged until the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (accept_start) begin
            overrun <= 1'b0;
        end else if (in_valid && (state_q != S_CAPTURE)) begin
            overrun <= 1'b1;
        end
    end

endmodule
